// File: rtl/contador_pkg.sv
// Shared definitions for the modulo-N counter.
// Holds the mode encodings seen on i_Mode and the mode type used when
// decoding them.
package contador_pkg;

    localparam int MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        UP_SAT   = 2'b00,
        UP_WRAP  = 2'b01,
        DOWN_SAT = 2'b10,
        PINGPONG = 2'b11
    } mode_e;

endpackage

// File: rtl/contador_modo_n_if.sv
// Control/status bundle of the modulo-N counter.
//   i_En    count enable
//   i_Load  synchronous load strobe
//   i_D     load value
//   i_Step  step magnitude per enabled cycle
//   i_Mode  counting mode (see contador_pkg)
//   o_Q     registered count
//   o_AtTop o_Q == TOP
//   o_AtBot o_Q == BOTTOM
//   o_Tc    one-cycle boundary-event pulse
//   o_Dir   ping-pong direction, 0 up / 1 down
// master drives the controls, slave is the counter.
interface contador_modo_n_if #(
    parameter int W = 4
);
    import contador_pkg::*;

    logic              i_En;
    logic              i_Load;
    logic [W-1:0]      i_D;
    logic [W-1:0]      i_Step;
    logic [MODE_W-1:0] i_Mode;
    logic [W-1:0]      o_Q;
    logic              o_AtTop;
    logic              o_AtBot;
    logic              o_Tc;
    logic              o_Dir;

    modport master (
        output i_En, i_Load, i_D, i_Step, i_Mode,
        input  o_Q, o_AtTop, o_AtBot, o_Tc, o_Dir
    );

    modport slave (
        input  i_En, i_Load, i_D, i_Step, i_Mode,
        output o_Q, o_AtTop, o_AtBot, o_Tc, o_Dir
    );

endinterface

// File: rtl/contador_next.sv
// Combinational next-state logic of the modulo-N counter: load clamp,
// per-mode step, direction update and terminal-count detection.
// Ports:
//   q, dir          current count and ping-pong direction
//   en, load        enable and load strobe (load has priority)
//   d, step, mode   load value, step magnitude, counting mode
//   q_next, dir_next, tc_next   values to register on the next edge
module contador_next
    import contador_pkg::*;
#(
    parameter int W      = 4,
    parameter int TOP    = 9,
    parameter int BOTTOM = 0
) (
    input  logic [W-1:0]      q,
    input  logic              dir,
    input  logic              en,
    input  logic              load,
    input  logic [W-1:0]      d,
    input  logic [W-1:0]      step,
    input  logic [MODE_W-1:0] mode,
    output logic [W-1:0]      q_next,
    output logic              dir_next,
    output logic              tc_next
);

    localparam logic [W-1:0] TOP_Q = W'(TOP);
    localparam logic [W-1:0] BOT_Q = W'(BOTTOM);
    localparam logic [W:0]   TOP_X = (W+1)'(TOP);
    localparam logic [W:0]   BOT_X = (W+1)'(BOTTOM);

    // Limit comparisons are done one bit wider so Q+Step and BOTTOM+Step
    // can never wrap before being tested against the limits.
    logic [W:0]   q_x;
    logic [W:0]   sum;
    logic [W:0]   bot_step;
    logic [W-1:0] diff;

    assign q_x      = {1'b0, q};
    assign sum      = q_x + {1'b0, step};
    assign bot_step = BOT_X + {1'b0, step};
    // Only selected once q >= BOTTOM+step, so it cannot borrow.
    assign diff     = q - step;

    function automatic logic [W-1:0] clamp(input logic [W-1:0] v);
        if ({1'b0, v} > TOP_X)
            return TOP_Q;
        else if ({1'b0, v} < BOT_X)
            return BOT_Q;
        else
            return v;
    endfunction

    always_comb begin
        q_next   = q;
        dir_next = dir;
        tc_next  = 1'b0;
        if (load) begin
            q_next = clamp(d);
        end else if (en && (step != '0)) begin
            // Direction only carries meaning in ping-pong mode.
            dir_next = 1'b0;
            unique case (mode_e'(mode))
                UP_SAT: begin
                    q_next  = (sum > TOP_X) ? TOP_Q : sum[W-1:0];
                    // Sitting at TOP already must not re-pulse.
                    tc_next = (q != TOP_Q) && (sum >= TOP_X);
                end
                UP_WRAP: begin
                    if (sum > TOP_X) begin
                        q_next  = BOT_Q;
                        tc_next = 1'b1;
                    end else begin
                        q_next  = sum[W-1:0];
                    end
                end
                DOWN_SAT: begin
                    q_next  = (q_x < bot_step) ? BOT_Q : diff;
                    tc_next = (q != BOT_Q) && (q_x <= bot_step);
                end
                PINGPONG: begin
                    if (!dir) begin
                        if (sum >= TOP_X) begin
                            q_next   = TOP_Q;
                            dir_next = 1'b1;
                            tc_next  = 1'b1;
                        end else begin
                            q_next   = sum[W-1:0];
                        end
                    end else begin
                        if (q_x <= bot_step) begin
                            q_next   = BOT_Q;
                            dir_next = 1'b0;
                            tc_next  = 1'b1;
                        end else begin
                            q_next   = diff;
                            dir_next = 1'b1;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/contador_modo_n.sv
// Modulo-N up/down/ping-pong counter with saturation, wrap and load.
// Ports:
//   i_Clk   clock, rising edge
//   i_GRst  synchronous active-high reset (count to BOTTOM, dir up)
//   bus     control/status bundle (contador_modo_n_if.slave)
// Holds the count, direction and terminal-count registers; the next-state
// computation lives in contador_next.
module contador_modo_n
    import contador_pkg::*;
#(
    parameter int W      = 4,
    parameter int TOP    = 9,
    parameter int BOTTOM = 0
) (
    input logic               i_Clk,
    input logic               i_GRst,
    contador_modo_n_if.slave  bus
);

    localparam logic [W-1:0] TOP_Q = W'(TOP);
    localparam logic [W-1:0] BOT_Q = W'(BOTTOM);

    logic [W-1:0] q_r;
    logic [W-1:0] q_n;
    logic         dir_r;
    logic         dir_n;
    logic         tc_r;
    logic         tc_n;

    contador_next #(
        .W      (W),
        .TOP    (TOP),
        .BOTTOM (BOTTOM)
    ) u_next (
        .q        (q_r),
        .dir      (dir_r),
        .en       (bus.i_En),
        .load     (bus.i_Load),
        .d        (bus.i_D),
        .step     (bus.i_Step),
        .mode     (bus.i_Mode),
        .q_next   (q_n),
        .dir_next (dir_n),
        .tc_next  (tc_n)
    );

    always_ff @(posedge i_Clk) begin
        if (i_GRst) begin
            q_r   <= BOT_Q;
            dir_r <= 1'b0;
            tc_r  <= 1'b0;
        end else begin
            q_r   <= q_n;
            dir_r <= dir_n;
            tc_r  <= tc_n;
        end
    end

    assign bus.o_Q     = q_r;
    assign bus.o_Dir   = dir_r;
    assign bus.o_Tc    = tc_r;
    assign bus.o_AtTop = (q_r == TOP_Q);
    assign bus.o_AtBot = (q_r == BOT_Q);

endmodule

// File: tb/tb_contador_modo_n.sv
// Bench for contador_modo_n (W=4, TOP=9, BOTTOM=0): directed vector table
// followed by random traffic checked against an arithmetic reference model.
module tb_contador_modo_n;

    localparam int W   = 4;
    localparam int TOP = 9;
    localparam int BOT = 0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    contador_modo_n_if #(.W(W)) bus ();

    contador_modo_n #(
        .W      (W),
        .TOP    (TOP),
        .BOTTOM (BOT)
    ) dut (
        .i_Clk  (clk),
        .i_GRst (rst),
        .bus    (bus)
    );

    typedef struct {
        bit r;
        bit l;
        bit e;
        int d;
        int s;
        int md;
        int q;
        int dir;
        int tc;
    } vec_t;

    vec_t vecs[$];
    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    int mq   = 0;
    int mdir = 0;
    int mtc  = 0;

    function automatic vec_t mk(bit r, bit l, bit e, int d, int s, int md,
                                int q, int dir, int tc);
        vec_t v;
        v.r = r; v.l = l; v.e = e; v.d = d; v.s = s; v.md = md;
        v.q = q; v.dir = dir; v.tc = tc;
        return v;
    endfunction

    task automatic check(input string nm, input int idx, input logic [31:0] act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %0d expected %0d", nm, idx, act, exp);
        end
    endtask

    // Behaviour written straight from the mode rules using integers.
    task automatic model(input bit r, input bit l, input bit e, input int d, input int s, input int md);
        int nq;
        if (r) begin
            mq = BOT; mdir = 0; mtc = 0;
        end else if (l) begin
            mq  = (d > TOP) ? TOP : ((d < BOT) ? BOT : d);
            mtc = 0;
        end else if (!e || s == 0) begin
            mtc = 0;
        end else begin
            mtc = 0;
            nq  = mq;
            case (md)
                0: begin
                    nq = (mq + s > TOP) ? TOP : mq + s;
                    mtc = (nq == TOP && mq != TOP) ? 1 : 0;
                    mdir = 0;
                end
                1: begin
                    if (mq + s > TOP) begin nq = BOT; mtc = 1; end
                    else nq = mq + s;
                    mdir = 0;
                end
                2: begin
                    nq = (mq - s < BOT) ? BOT : mq - s;
                    mtc = (nq == BOT && mq != BOT) ? 1 : 0;
                    mdir = 0;
                end
                default: begin
                    if (mdir == 0) begin
                        if (mq + s >= TOP) begin nq = TOP; mdir = 1; mtc = 1; end
                        else nq = mq + s;
                    end else begin
                        if (mq - s <= BOT) begin nq = BOT; mdir = 0; mtc = 1; end
                        else nq = mq - s;
                    end
                end
            endcase
            mq = nq;
        end
    endtask

    task automatic drive(input bit r, input bit l, input bit e, input int d, input int s, input int md);
        @(negedge clk);
        rst        = r;
        bus.i_Load = l;
        bus.i_En   = e;
        bus.i_D    = W'(d);
        bus.i_Step = W'(s);
        bus.i_Mode = 2'(md);
        @(posedge clk);
        #1;
        model(r, l, e, d, s, md);
    endtask

    initial begin
        bus.i_Load = 1'b0;
        bus.i_En   = 1'b0;
        bus.i_D    = '0;
        bus.i_Step = '0;
        bus.i_Mode = '0;
        repeat (2) @(posedge clk);

        //             r  l  e  d  s md   q dir tc
        vecs.push_back(mk(1, 0, 1, 0, 1, 0,  0, 0, 0));
        for (int k = 1; k <= 11; k++)
            vecs.push_back(mk(0, 0, 1, 0, 1, 0, (k > 9) ? 9 : k, 0, (k == 9) ? 1 : 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0,  0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 3, 1,  3, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 3, 1,  6, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 3, 1,  9, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 3, 1,  0, 0, 1));
        vecs.push_back(mk(0, 0, 1, 0, 3, 1,  3, 0, 0));
        vecs.push_back(mk(0, 1, 0, 5, 0, 1,  5, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 2, 2,  3, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 2, 2,  1, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 2, 2,  0, 0, 1));
        vecs.push_back(mk(0, 0, 1, 0, 2, 2,  0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0,  0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 4, 3,  4, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 4, 3,  8, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 4, 3,  9, 1, 1));
        vecs.push_back(mk(0, 0, 1, 0, 4, 3,  5, 1, 0));
        vecs.push_back(mk(0, 0, 1, 0, 4, 3,  1, 1, 0));
        vecs.push_back(mk(0, 0, 1, 0, 4, 3,  0, 0, 1));
        vecs.push_back(mk(0, 0, 1, 0, 4, 3,  4, 0, 0));
        vecs.push_back(mk(0, 1, 0, 12, 0, 0, 9, 0, 0));
        vecs.push_back(mk(0, 1, 1, 3, 1, 0,  3, 0, 0));
        vecs.push_back(mk(1, 1, 1, 7, 1, 0,  0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 4, 3,  4, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 4, 3,  8, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 4, 3,  9, 1, 1));
        for (int k = 0; k < 5; k++)
            vecs.push_back(mk(0, 0, 0, 0, 4, 3, 9, 1, 0));
        for (int k = 0; k < 5; k++)
            vecs.push_back(mk(0, 0, 1, 0, 0, 3, 9, 1, 0));
        vecs.push_back(mk(0, 0, 1, 0, 1, 0,  9, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 1, 0,  9, 0, 0));
        vecs.push_back(mk(0, 1, 0, 2, 0, 0,  2, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 1, 0,  3, 0, 0));
        vecs.push_back(mk(1, 0, 1, 0, 1, 0,  0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 1, 0,  1, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 2, 2,  0, 0, 1));
        vecs.push_back(mk(0, 0, 1, 0, 2, 2,  0, 0, 0));

        foreach (vecs[i]) begin
            drive(vecs[i].r, vecs[i].l, vecs[i].e, vecs[i].d, vecs[i].s, vecs[i].md);
            check("vec_q",     i, 32'(bus.o_Q),     vecs[i].q);
            check("vec_dir",   i, 32'(bus.o_Dir),   vecs[i].dir);
            check("vec_tc",    i, 32'(bus.o_Tc),    vecs[i].tc);
            check("vec_attop", i, 32'(bus.o_AtTop), (vecs[i].q == TOP) ? 1 : 0);
            check("vec_atbot", i, 32'(bus.o_AtBot), (vecs[i].q == BOT) ? 1 : 0);
        end

        for (int i = 0; i < 400; i++) begin
            bit r, l, e;
            int d, s, md;
            r  = ($urandom_range(0, 39) == 0);
            l  = ($urandom_range(0, 7) == 0);
            e  = ($urandom_range(0, 3) != 0);
            d  = $urandom_range(0, 15);
            s  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 4);
            md = $urandom_range(0, 3);
            drive(r, l, e, d, s, md);
            check("rnd_q",     i, 32'(bus.o_Q),     mq);
            check("rnd_dir",   i, 32'(bus.o_Dir),   mdir);
            check("rnd_tc",    i, 32'(bus.o_Tc),    mtc);
            check("rnd_attop", i, 32'(bus.o_AtTop), (mq == TOP) ? 1 : 0);
            check("rnd_atbot", i, 32'(bus.o_AtBot), (mq == BOT) ? 1 : 0);
            check("rnd_range", i, 32'((int'(bus.o_Q) >= BOT) && (int'(bus.o_Q) <= TOP)), 1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
